// File: rtl/rv64_int_core.sv
// rv64_int_core: RV64I decode, 32x64 register file and integer ALU, one instruction per exec_en strobe.
// Define RV_MUL_EN to add MUL and MULW.
module rv64_int_core (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] inst,
    input  logic [63:0] pc,
    input  logic        exec_en,
    input  logic [4:0]  dbg_addr,
    output logic [63:0] dbg_data,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic [63:0] imm,
    output logic        wb_en,
    output logic [63:0] wb_data,
    output logic        unsupported,
    output logic        halt
);
    localparam logic [6:0] OP_OP      = 7'b0110011;
    localparam logic [6:0] OP_IMM     = 7'b0010011;
    localparam logic [6:0] OP_32      = 7'b0111011;
    localparam logic [6:0] OP_IMM_32  = 7'b0011011;
    localparam logic [6:0] OP_LUI     = 7'b0110111;
    localparam logic [6:0] OP_AUIPC   = 7'b0010111;
    localparam logic [6:0] OP_STORE   = 7'b0100011;
    localparam logic [6:0] OP_BRANCH  = 7'b1100011;
    localparam logic [6:0] OP_JAL     = 7'b1101111;

    logic [6:0]  op, funct7;
    logic [2:0]  funct3;
    logic [63:0] regs_q [32];
    logic [63:0] regs_d [32];
    logic [63:0] a, b, sum, sra64, res64, prod, alu;
    logic [31:0] sra32, res32;
    logic [5:0]  sh6;
    logic [4:0]  sh5;
    logic        is_op, is_opimm, is_op32, is_opimm32, is_lui, is_auipc;
    logic        word, reg_b, alt, f7_zero, f7_alt, mul_ok, supported;
    logic        op_ok, op32_ok, opimm_ok, opimm32_ok;

    assign op     = inst[6:0];
    assign rd     = inst[11:7];
    assign funct3 = inst[14:12];
    assign rs1    = inst[19:15];
    assign rs2    = inst[24:20];
    assign funct7 = inst[31:25];
    assign halt   = inst == 32'h0;

    assign imm = op == OP_STORE ? {{52{inst[31]}}, inst[31:25], inst[11:7]} :
                 op == OP_BRANCH ? {{51{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0} :
                 (op == OP_LUI || op == OP_AUIPC) ? {{32{inst[31]}}, inst[31:12], 12'b0} :
                 op == OP_JAL ? {{43{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0} :
                 {{52{inst[31]}}, inst[31:20]};

    assign is_op      = op == OP_OP;
    assign is_opimm   = op == OP_IMM;
    assign is_op32    = op == OP_32;
    assign is_opimm32 = op == OP_IMM_32;
    assign is_lui     = op == OP_LUI;
    assign is_auipc   = op == OP_AUIPC;
    assign word       = is_op32 | is_opimm32;
    assign reg_b      = is_op | is_op32;
    assign alt        = inst[30];
    assign f7_zero    = funct7 == 7'b0000000;
    assign f7_alt     = funct7 == 7'b0100000;

`ifdef RV_MUL_EN
    assign mul_ok = funct7 == 7'b0000001 && funct3 == 3'd0;
    assign prod   = a * b;
`else
    assign mul_ok = 1'b0;
    assign prod   = '0;
`endif

    // 64-bit immediate shifts carry shamt[5] in inst[25], so only inst[31:26] qualifies the encoding
    assign op_ok      = f7_zero | (f7_alt & (funct3 == 3'd0 | funct3 == 3'd5)) | mul_ok;
    assign op32_ok    = ((funct3 == 3'd0 | funct3 == 3'd5) & (f7_zero | f7_alt)) |
                        (funct3 == 3'd1 & f7_zero) | mul_ok;
    assign opimm_ok   = funct3 == 3'd1 ? inst[31:26] == 6'b0 :
                        funct3 == 3'd5 ? (inst[31:26] == 6'b0 | inst[31:26] == 6'b010000) : 1'b1;
    assign opimm32_ok = funct3 == 3'd0 | (funct3 == 3'd1 & f7_zero) |
                        (funct3 == 3'd5 & (f7_zero | f7_alt));
    assign supported  = (is_op & op_ok) | (is_op32 & op32_ok) | (is_opimm & opimm_ok) |
                        (is_opimm32 & opimm32_ok) | is_lui | is_auipc;
    assign unsupported = ~supported;
    assign wb_en       = exec_en & supported;

    assign a        = rs1 == 5'd0 ? 64'd0 : regs_q[rs1];
    assign b        = reg_b ? (rs2 == 5'd0 ? 64'd0 : regs_q[rs2]) : imm;
    assign dbg_data = dbg_addr == 5'd0 ? 64'd0 : regs_q[dbg_addr];
    assign sh6      = b[5:0];
    assign sh5      = b[4:0];
    assign sum      = (alt & reg_b) ? a - b : a + b;
    assign sra64    = $signed(a) >>> sh6;
    assign sra32    = $signed(a[31:0]) >>> sh5;
    assign res32    = funct3 == 3'd1 ? a[31:0] << sh5 :
                      funct3 == 3'd5 ? (alt ? sra32 : a[31:0] >> sh5) : sum[31:0];

    always_comb begin
        case (funct3)
            3'd1:    res64 = a << sh6;
            3'd2:    res64 = {63'b0, $signed(a) < $signed(b)};
            3'd3:    res64 = {63'b0, a < b};
            3'd4:    res64 = a ^ b;
            3'd5:    res64 = alt ? sra64 : a >> sh6;
            3'd6:    res64 = a | b;
            3'd7:    res64 = a & b;
            default: res64 = sum;
        endcase
    end

    assign alu = (mul_ok & reg_b) ? (word ? {{32{prod[31]}}, prod[31:0]} : prod) :
                 word ? {{32{res32[31]}}, res32} : res64;
    assign wb_data = is_lui ? imm : is_auipc ? pc + imm : alu;

    always_comb begin
        regs_d = regs_q;
        if (wb_en && rd != 5'd0) regs_d[rd] = wb_data;
    end

    always_ff @(posedge clk) begin
        if (reset) regs_q <= '{default: '0};
        else regs_q <= regs_d;
    end
endmodule

// File: tb/tb_rv64_int_core.sv
// tb_rv64_int_core: directed test-plan scenarios plus randomized instructions against a mnemonic-level model.
module tb_rv64_int_core;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] inst = 32'h13;
    logic [63:0] pc = 64'h0;
    logic        exec_en = 1'b0;
    logic [4:0]  dbg_addr = 5'd0;
    logic [63:0] dbg_data, imm, wb_data;
    logic [4:0]  rs1, rs2, rd;
    logic        wb_en, unsupported, halt;
    logic [63:0] mreg [32];
    int checks = 0;
    int passed = 0;

`ifdef RV_MUL_EN
    localparam bit MUL_EN = 1'b1;
`else
    localparam bit MUL_EN = 1'b0;
`endif

    rv64_int_core dut (
        .clk(clk), .reset(reset), .inst(inst), .pc(pc), .exec_en(exec_en),
        .dbg_addr(dbg_addr), .dbg_data(dbg_data), .rs1(rs1), .rs2(rs2), .rd(rd),
        .imm(imm), .wb_en(wb_en), .wb_data(wb_data), .unsupported(unsupported), .halt(halt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] enc_i(logic [11:0] im, logic [4:0] s1, logic [2:0] f3, logic [4:0] d, logic [6:0] o);
        return {im, s1, f3, d, o};
    endfunction

    function automatic logic [31:0] enc_r(logic [6:0] f7, logic [4:0] s2, logic [4:0] s1, logic [2:0] f3, logic [4:0] d, logic [6:0] o);
        return {f7, s2, s1, f3, d, o};
    endfunction

    function automatic logic [31:0] enc_u(logic [19:0] im, logic [4:0] d, logic [6:0] o);
        return {im, d, o};
    endfunction

    function automatic logic [63:0] w(logic [31:0] x);
        return {{32{x[31]}}, x};
    endfunction

    function automatic logic [63:0] ref_imm(logic [31:0] i);
        case (i[6:0])
            7'h23:        return 64'(signed'({i[31:25], i[11:7]}));
            7'h63:        return 64'(signed'({i[31], i[7], i[30:25], i[11:8], 1'b0}));
            7'h37, 7'h17: return 64'(signed'({i[31:12], 12'b0}));
            7'h6F:        return 64'(signed'({i[31], i[19:12], i[20], i[30:21], 1'b0}));
            default:      return 64'(signed'(i[31:20]));
        endcase
    endfunction

    // Returns {supported, result} for the instruction against the current model registers.
    function automatic logic [64:0] ref_exec(logic [31:0] i, logic [63:0] p);
        logic [63:0] a, b, im, r;
        logic [6:0] f7;
        logic [2:0] f3;
        bit ok;
        a = mreg[i[19:15]];
        b = mreg[i[24:20]];
        im = ref_imm(i);
        f7 = i[31:25];
        f3 = i[14:12];
        ok = 1'b1;
        r = 64'd0;
        case (i[6:0])
            7'h33: begin
                if (f7 == 7'h00) begin
                    case (f3)
                        3'd0: r = a + b;
                        3'd1: r = a << b[5:0];
                        3'd2: r = (longint'(a) < longint'(b)) ? 64'd1 : 64'd0;
                        3'd3: r = (a < b) ? 64'd1 : 64'd0;
                        3'd4: r = a ^ b;
                        3'd5: r = a >> b[5:0];
                        3'd6: r = a | b;
                        default: r = a & b;
                    endcase
                end else if (f7 == 7'h20 && f3 == 3'd0) r = a - b;
                else if (f7 == 7'h20 && f3 == 3'd5) r = longint'(a) >>> b[5:0];
                else if (MUL_EN && f7 == 7'h01 && f3 == 3'd0) r = a * b;
                else ok = 1'b0;
            end
            7'h13: begin
                case (f3)
                    3'd0: r = a + im;
                    3'd1: if (i[31:26] == 6'd0) r = a << i[25:20]; else ok = 1'b0;
                    3'd2: r = (longint'(a) < longint'(im)) ? 64'd1 : 64'd0;
                    3'd3: r = (a < im) ? 64'd1 : 64'd0;
                    3'd4: r = a ^ im;
                    3'd5: if (i[31:26] == 6'd0) r = a >> i[25:20];
                          else if (i[31:26] == 6'h10) r = longint'(a) >>> i[25:20];
                          else ok = 1'b0;
                    3'd6: r = a | im;
                    default: r = a & im;
                endcase
            end
            7'h3B: begin
                if (f7 == 7'h00 && f3 == 3'd0) r = w(a[31:0] + b[31:0]);
                else if (f7 == 7'h20 && f3 == 3'd0) r = w(a[31:0] - b[31:0]);
                else if (f7 == 7'h00 && f3 == 3'd1) r = w(a[31:0] << b[4:0]);
                else if (f7 == 7'h00 && f3 == 3'd5) r = w(a[31:0] >> b[4:0]);
                else if (f7 == 7'h20 && f3 == 3'd5) r = w(int'(a[31:0]) >>> b[4:0]);
                else if (MUL_EN && f7 == 7'h01 && f3 == 3'd0) r = w(a[31:0] * b[31:0]);
                else ok = 1'b0;
            end
            7'h1B: begin
                if (f3 == 3'd0) r = w(a[31:0] + im[31:0]);
                else if (f7 == 7'h00 && f3 == 3'd1) r = w(a[31:0] << i[24:20]);
                else if (f7 == 7'h00 && f3 == 3'd5) r = w(a[31:0] >> i[24:20]);
                else if (f7 == 7'h20 && f3 == 3'd5) r = w(int'(a[31:0]) >>> i[24:20]);
                else ok = 1'b0;
            end
            7'h37: r = im;
            7'h17: r = p + im;
            default: ok = 1'b0;
        endcase
        return {ok, r};
    endfunction

    task automatic run(input logic [31:0] i, input logic [63:0] p);
        logic [64:0] r;
        @(negedge clk);
        inst = i;
        pc = p;
        exec_en = 1'b1;
        #1 r = ref_exec(i, p);
        @(posedge clk);
        #1 exec_en = 1'b0;
        if (r[64] && i[11:7] != 5'd0) mreg[i[11:7]] = r[63:0];
    endtask

    task automatic peek(input logic [4:0] ad, output logic [63:0] v);
        dbg_addr = ad;
        #1 v = dbg_data;
    endtask

    task automatic test_reset;
        logic [63:0] v;
        @(negedge clk);
        reset = 1'b1;
        exec_en = 1'b1;
        inst = enc_i(12'h123, 5'd0, 3'd0, 5'd1, 7'h13);
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        exec_en = 1'b0;
        for (int k = 0; k < 32; k++) mreg[k] = 64'd0;
        for (int k = 0; k < 32; k++) begin
            peek(5'(k), v);
            checks++;
            if (v !== 64'd0) $display("FAIL reset_x%0d got %h expected 0", k, v); else passed++;
        end
        run(enc_i(12'd5, 5'd0, 3'd0, 5'd0, 7'h13), 64'd0);
        peek(5'd0, v);
        checks++;
        if (v !== 64'd0) $display("FAIL x0_write got %h expected 0", v); else passed++;
    endtask

    task automatic test_arith;
        logic [63:0] v;
        run(enc_i(12'hFFF, 5'd0, 3'd0, 5'd1, 7'h13), 64'd0);
        run(enc_i(12'd3, 5'd0, 3'd0, 5'd2, 7'h13), 64'd0);
        run(enc_r(7'h00, 5'd2, 5'd1, 3'd2, 5'd3, 7'h33), 64'd0);
        run(enc_r(7'h00, 5'd2, 5'd1, 3'd3, 5'd4, 7'h33), 64'd0);
        run(enc_r(7'h20, 5'd1, 5'd2, 3'd0, 5'd5, 7'h33), 64'd0);
        peek(5'd1, v);
        checks++;
        if (v !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL addi_x1 got %h expected all ones", v); else passed++;
        peek(5'd2, v);
        checks++;
        if (v !== 64'd3) $display("FAIL addi_x2 got %h expected 3", v); else passed++;
        peek(5'd3, v);
        checks++;
        if (v !== 64'd1) $display("FAIL slt got %h expected 1", v); else passed++;
        peek(5'd4, v);
        checks++;
        if (v !== 64'd0) $display("FAIL sltu got %h expected 0", v); else passed++;
        peek(5'd5, v);
        checks++;
        if (v !== 64'd4) $display("FAIL sub got %h expected 4", v); else passed++;
    endtask

    task automatic test_shifts;
        logic [63:0] v;
        run(enc_i(12'd60, 5'd1, 3'd5, 5'd6, 7'h13), 64'd0);
        run(enc_i(12'h43C, 5'd1, 3'd5, 5'd7, 7'h13), 64'd0);
        run(enc_i(12'd4, 5'd1, 3'd5, 5'd8, 7'h1B), 64'd0);
        run(enc_i(12'h7FF, 5'd0, 3'd0, 5'd9, 7'h1B), 64'd0);
        run(enc_i(12'd21, 5'd9, 3'd1, 5'd9, 7'h1B), 64'd0);
        peek(5'd6, v);
        checks++;
        if (v !== 64'hF) $display("FAIL srli got %h expected f", v); else passed++;
        peek(5'd7, v);
        checks++;
        if (v !== 64'hFFFF_FFFF_FFFF_FFFF) $display("FAIL srai got %h expected all ones", v); else passed++;
        peek(5'd8, v);
        checks++;
        if (v !== 64'h0000_0000_0FFF_FFFF) $display("FAIL srliw got %h expected 0fffffff", v); else passed++;
        peek(5'd9, v);
        checks++;
        if (v !== 64'hFFFF_FFFF_FFE0_0000) $display("FAIL slliw got %h expected ffffffffffe00000", v); else passed++;
    endtask

    task automatic test_upper;
        logic [63:0] v;
        run(enc_u(20'h80000, 5'd10, 7'h37), 64'd0);
        run(enc_u(20'h00001, 5'd11, 7'h17), 64'h1000);
        peek(5'd10, v);
        checks++;
        if (v !== 64'hFFFF_FFFF_8000_0000) $display("FAIL lui got %h expected ffffffff80000000", v); else passed++;
        peek(5'd11, v);
        checks++;
        if (v !== 64'h2000) $display("FAIL auipc got %h expected 2000", v); else passed++;
    endtask

    task automatic test_stale;
        logic [63:0] v;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            inst = enc_i(12'd1, 5'd1, 3'd0, 5'd1, 7'h13);
            exec_en = (c == 2);
        end
        @(negedge clk);
        exec_en = 1'b0;
        mreg[1] = mreg[1] + 64'd1;
        peek(5'd1, v);
        checks++;
        if (v !== 64'd0) $display("FAIL stale_inst got %h expected 0", v); else passed++;
    endtask

    task automatic test_unsupported;
        logic [63:0] v;
        @(negedge clk);
        inst = enc_i(12'd0, 5'd1, 3'd2, 5'd13, 7'h03);
        exec_en = 1'b1;
        #1;
        checks++;
        if (unsupported !== 1'b1 || wb_en !== 1'b0 || halt !== 1'b0)
            $display("FAIL load_flags got u=%b wb=%b h=%b expected u=1 wb=0 h=0", unsupported, wb_en, halt);
        else passed++;
        @(posedge clk);
        #1 exec_en = 1'b0;
        for (int k = 0; k < 32; k++) begin
            peek(5'(k), v);
            checks++;
            if (v !== mreg[k]) $display("FAIL load_noeffect_x%0d got %h expected %h", k, v, mreg[k]); else passed++;
        end
        @(negedge clk);
        inst = 32'h0;
        #1;
        checks++;
        if (halt !== 1'b1 || unsupported !== 1'b1) $display("FAIL halt got h=%b u=%b expected h=1 u=1", halt, unsupported); else passed++;
    endtask

    task automatic test_mul;
        logic [63:0] v;
        logic [63:0] expv;
        @(negedge clk);
        inst = enc_r(7'h01, 5'd2, 5'd2, 3'd0, 5'd12, 7'h33);
        exec_en = 1'b1;
        #1;
        checks++;
        if (unsupported !== !MUL_EN) $display("FAIL mul_unsupported got %b expected %b", unsupported, !MUL_EN); else passed++;
        @(posedge clk);
        #1 exec_en = 1'b0;
        expv = MUL_EN ? 64'd9 : mreg[12];
        mreg[12] = expv;
        peek(5'd12, v);
        checks++;
        if (v !== expv) $display("FAIL mul_x12 got %h expected %h", v, expv); else passed++;
    endtask

    task automatic test_mid_reset;
        logic [63:0] v;
        run(enc_i(12'd77, 5'd0, 3'd0, 5'd5, 7'h13), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        exec_en = 1'b1;
        inst = enc_i(12'd1, 5'd0, 3'd0, 5'd6, 7'h13);
        @(posedge clk);
        #1 reset = 1'b0;
        exec_en = 1'b0;
        for (int k = 0; k < 32; k++) mreg[k] = 64'd0;
        peek(5'd5, v);
        checks++;
        if (v !== 64'd0) $display("FAIL midreset_x5 got %h expected 0", v); else passed++;
        peek(5'd6, v);
        checks++;
        if (v !== 64'd0) $display("FAIL midreset_dropped_x6 got %h expected 0", v); else passed++;
    endtask

    task automatic test_random;
        logic [6:0] ops [12] = '{7'h33, 7'h13, 7'h3B, 7'h1B, 7'h37, 7'h17, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h73, 7'h0B};
        logic [6:0] f7, o;
        logic [31:0] i;
        logic [63:0] p, v;
        logic [64:0] r;
        logic en, rst;
        int pick;
        for (int n = 0; n < 400; n++) begin
            pick = $urandom_range(0, 3);
            f7 = pick == 0 ? 7'h00 : pick == 1 ? 7'h20 : pick == 2 ? 7'h01 : 7'($urandom);
            o = ops[$urandom_range(0, 11)];
            i = {f7, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 3'($urandom), 5'($urandom_range(0, 7)), o};
            p = {$urandom, $urandom};
            en = $urandom_range(0, 3) != 0;
            rst = $urandom_range(0, 49) == 0;
            @(negedge clk);
            inst = i;
            pc = p;
            exec_en = en;
            reset = rst;
            #1 r = ref_exec(i, p);
            checks++;
            if (unsupported !== !r[64] || wb_en !== (en & r[64]) || halt !== (i == 32'h0))
                $display("FAIL rnd_flags inst=%h got u=%b wb=%b h=%b expected u=%b wb=%b h=%b",
                         i, unsupported, wb_en, halt, !r[64], en & r[64], i == 32'h0);
            else passed++;
            checks++;
            if (rd !== i[11:7] || rs1 !== i[19:15] || rs2 !== i[24:20])
                $display("FAIL rnd_fields inst=%h got %0d/%0d/%0d", i, rd, rs1, rs2);
            else passed++;
            if (o != 7'h33 && o != 7'h3B && o != 7'h0B) begin
                checks++;
                if (imm !== ref_imm(i)) $display("FAIL rnd_imm inst=%h got %h expected %h", i, imm, ref_imm(i)); else passed++;
            end
            if (r[64]) begin
                checks++;
                if (wb_data !== r[63:0]) $display("FAIL rnd_wb_data inst=%h got %h expected %h", i, wb_data, r[63:0]); else passed++;
            end
            @(posedge clk);
            #1 reset = 1'b0;
            exec_en = 1'b0;
            if (rst) for (int k = 0; k < 32; k++) mreg[k] = 64'd0;
            else if (en && r[64] && i[11:7] != 5'd0) mreg[i[11:7]] = r[63:0];
            peek(i[11:7], v);
            checks++;
            if (v !== mreg[i[11:7]]) $display("FAIL rnd_reg inst=%h x%0d got %h expected %h", i, i[11:7], v, mreg[i[11:7]]); else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shifts();
        test_upper();
        test_stale();
        test_unsupported();
        test_mul();
        test_mid_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
